// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// store_queue : in-order store buffer (dispatch -> AGU fill -> commit -> drain)
// Revision    : 1.0
// ============================================================================
module store_queue #(
  parameter int SQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_valid,
  input  logic [ROB_IDX_W-1:0] dispatch_rob_id,
  output logic                 dispatch_ready,
  input  logic                 agu_valid,
  input  logic [ROB_IDX_W-1:0] agu_rob_id,
  input  logic [31:0]          agu_addr,
  input  logic [3:0]           agu_mask,
  input  logic [31:0]          agu_wdata,
  output logic                 commit_head_ready,
  output logic [ROB_IDX_W-1:0] commit_head_rob_id,
  input  logic                 commit_valid,
  input  logic                 flush,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_resp_valid
);

  localparam int c_IDX_W = $clog2(SQ_DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_ALLOC     = 2'd1,
    S_FILLED    = 2'd2,
    S_COMMITTED = 2'd3
  } entry_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_REQ  = 2'd1,
    D_WAIT = 2'd2
  } drain_state_t;

  entry_state_t         ent_q   [SQ_DEPTH];
  entry_state_t         ent_d   [SQ_DEPTH];
  logic [ROB_IDX_W-1:0] rob_q   [SQ_DEPTH];
  logic [ROB_IDX_W-1:0] rob_d   [SQ_DEPTH];
  logic [29:0]          addr_q  [SQ_DEPTH];
  logic [29:0]          addr_d  [SQ_DEPTH];
  logic [3:0]           mask_q  [SQ_DEPTH];
  logic [3:0]           mask_d  [SQ_DEPTH];
  logic [31:0]          wdata_q [SQ_DEPTH];
  logic [31:0]          wdata_d [SQ_DEPTH];

  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] commit_q, commit_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  drain_state_t       drain_q, drain_d;

  logic [c_IDX_W-1:0] w_head_idx;
  logic [c_IDX_W-1:0] w_commit_idx;
  logic [c_IDX_W-1:0] w_tail_idx;
  logic               w_full;
  logic               w_dispatch_fire;
  logic               w_commit_fire;
  logic               unused_addr_lo;

  assign w_head_idx   = head_q[c_IDX_W-1:0];
  assign w_commit_idx = commit_q[c_IDX_W-1:0];
  assign w_tail_idx   = tail_q[c_IDX_W-1:0];
  assign w_full       = (w_tail_idx == w_head_idx) && (tail_q[c_IDX_W] != head_q[c_IDX_W]);

  assign dispatch_ready     = !w_full;
  assign commit_head_ready  = (commit_q != tail_q) && (ent_q[w_commit_idx] == S_FILLED);
  assign commit_head_rob_id = rob_q[w_commit_idx];

  assign w_dispatch_fire = dispatch_valid && dispatch_ready && !flush;
  assign w_commit_fire   = commit_valid && commit_head_ready;

  assign dmem_req_valid = (drain_q == D_REQ);
  assign dmem_addr      = {addr_q[w_head_idx], 2'b00};
  assign dmem_wmask     = mask_q[w_head_idx];
  assign dmem_wdata     = wdata_q[w_head_idx];
  assign unused_addr_lo = ^agu_addr[1:0];

  always_comb begin
    ent_d    = ent_q;
    rob_d    = rob_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    head_d   = head_q;
    commit_d = commit_q;
    tail_d   = tail_q;
    drain_d  = drain_q;

    // Uncommitted entries are exactly those in ALLOC or FILLED, so flush squashes by state.
    if (flush) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (ent_q[i] == S_ALLOC || ent_q[i] == S_FILLED) begin
          ent_d[i] = S_EMPTY;
        end
      end
    end

    if (w_commit_fire) begin
      ent_d[w_commit_idx] = S_COMMITTED;
      commit_d            = commit_q + c_PTR_ONE;
    end

    if (flush) begin
      tail_d = commit_d;
    end else begin
      if (w_dispatch_fire) begin
        ent_d[w_tail_idx] = S_ALLOC;
        rob_d[w_tail_idx] = dispatch_rob_id;
        tail_d            = tail_q + c_PTR_ONE;
      end
      if (agu_valid) begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
          if (ent_q[i] == S_ALLOC && rob_q[i] == agu_rob_id) begin
            ent_d[i]   = S_FILLED;
            addr_d[i]  = agu_addr[31:2];
            mask_d[i]  = agu_mask;
            wdata_d[i] = agu_wdata;
          end
        end
      end
    end

    case (drain_q)
      D_IDLE: begin
        if (head_q != commit_q) begin
          drain_d = D_REQ;
        end
      end
      D_REQ: begin
        if (dmem_req_ready) begin
          drain_d = D_WAIT;
        end
      end
      D_WAIT: begin
        if (dmem_resp_valid) begin
          ent_d[w_head_idx] = S_EMPTY;
          head_d            = head_q + c_PTR_ONE;
          drain_d           = D_IDLE;
        end
      end
      default: drain_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      drain_q  <= D_IDLE;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        ent_q[i]   <= S_EMPTY;
        rob_q[i]   <= '0;
        addr_q[i]  <= '0;
        mask_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      drain_q  <= drain_d;
      ent_q    <= ent_d;
      rob_q    <= rob_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
    end
  end

  a_commit_needs_ready : assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> commit_head_ready);

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
// tb_store_queue : directed stimulus with scoreboard-checked cache drain
// Revision       : 1.0
// ============================================================================
module tb_store_queue;

  logic        clk;
  logic        rst;
  logic        dispatch_valid;
  logic [4:0]  dispatch_rob_id;
  logic        dispatch_ready;
  logic        agu_valid;
  logic [4:0]  agu_rob_id;
  logic [31:0] agu_addr;
  logic [3:0]  agu_mask;
  logic [31:0] agu_wdata;
  logic        commit_head_ready;
  logic [4:0]  commit_head_rob_id;
  logic        commit_valid;
  logic        flush;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp_valid;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   acc_count;
  int   push_count;
  int   stray_cnt;
  int   stray_done;
  logic auto_ready;
  logic resp_en;
  logic resp_due;

  store_queue #(.SQ_DEPTH(8), .ROB_IDX_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .dispatch_valid     (dispatch_valid),
    .dispatch_rob_id    (dispatch_rob_id),
    .dispatch_ready     (dispatch_ready),
    .agu_valid          (agu_valid),
    .agu_rob_id         (agu_rob_id),
    .agu_addr           (agu_addr),
    .agu_mask           (agu_mask),
    .agu_wdata          (agu_wdata),
    .commit_head_ready  (commit_head_ready),
    .commit_head_rob_id (commit_head_rob_id),
    .commit_valid       (commit_valid),
    .flush              (flush),
    .dmem_req_valid     (dmem_req_valid),
    .dmem_req_ready     (dmem_req_ready),
    .dmem_addr          (dmem_addr),
    .dmem_wmask         (dmem_wmask),
    .dmem_wdata         (dmem_wdata),
    .dmem_resp_valid    (dmem_resp_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache model + monitor: acts 2 time units after each rising edge.
  initial begin
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    resp_due        = 1'b0;
    acc_count       = 0;
    stray_done      = 0;
    forever begin
      exp_t e;
      @(posedge clk);
      #2;
      dmem_resp_valid = resp_due && resp_en;
      resp_due        = 1'b0;
      if (stray_cnt != stray_done) begin
        dmem_resp_valid = 1'b1;
        stray_done++;
      end
      dmem_req_ready = auto_ready;
      if (dmem_req_valid && dmem_req_ready) begin
        acc_count++;
        resp_due = 1'b1;
        check("sb_expected_present", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("drain_addr", dmem_addr, e.addr);
          check("drain_mask", dmem_wmask, e.mask);
          check("drain_data", dmem_wdata, e.data);
        end
      end
    end
  end

  task automatic op(input logic dv, input logic [4:0] drob, input logic av, input logic [4:0] arob,
                    input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                    input logic cv, input logic fl);
    dispatch_valid  = dv;
    dispatch_rob_id = drob;
    agu_valid       = av;
    agu_rob_id      = arob;
    agu_addr        = addr;
    agu_mask        = mask;
    agu_wdata       = data;
    commit_valid    = cv;
    flush           = fl;
    @(negedge clk);
    dispatch_valid = 1'b0;
    agu_valid      = 1'b0;
    commit_valid   = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] rob);
    op(1'b1, rob, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic [4:0] rob, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data);
    op(1'b0, 5'd0, 1'b1, rob, addr, mask, data, 1'b0, 1'b0);
  endtask

  task automatic do_commit(input logic [4:0] rob, input logic [31:0] ea, input logic [3:0] em,
                           input logic [31:0] ed);
    check("commit_head_ready", commit_head_ready, 1);
    check("commit_head_rob_id", commit_head_rob_id, rob);
    if (commit_head_ready) begin
      exp_q.push_back('{ea, em, ed});
      push_count++;
      op(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_complete", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int a0;
    logic [3:0] m;
    n_checks = 0; n_fail = 0; push_count = 0; stray_cnt = 0;
    rst = 1'b1; auto_ready = 1'b0; resp_en = 1'b1;
    dispatch_valid = 1'b0; dispatch_rob_id = '0; agu_valid = 1'b0; agu_rob_id = '0;
    agu_addr = '0; agu_mask = '0; agu_wdata = '0; commit_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dispatch_ready", dispatch_ready, 1);
    check("rst_commit_head_ready", commit_head_ready, 0);
    check("rst_commit_head_rob_id", commit_head_rob_id, 0);
    check("rst_dmem_req_valid", dmem_req_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic single store
    auto_ready = 1'b1;
    dispatch(5'd3);
    check("t1_head_not_ready", commit_head_ready, 0);
    fill(5'd3, 32'h0000_1002, 4'b0100, 32'h00AB_0000);
    do_commit(5'd3, 32'h0000_1000, 4'b0100, 32'h00AB_0000);
    wait_drain();

    // Full queue, single free, refill across wrap
    auto_ready = 1'b0;
    for (int i = 0; i < 8; i++) dispatch(5'(i));
    check("t2_full", dispatch_ready, 0);
    dispatch(5'd31);
    check("t2_full_hold", dispatch_ready, 0);
    for (int i = 0; i < 8; i++) begin
      m = (i % 2 == 1) ? 4'b0011 : 4'b1100;
      fill(5'(i), 32'h0000_2001 + 32'(i * 4), m, 32'hD000_0000 + 32'(i));
    end
    for (int i = 0; i < 8; i++) begin
      m = (i % 2 == 1) ? 4'b0011 : 4'b1100;
      do_commit(5'(i), 32'h0000_2000 + 32'(i * 4), m, 32'hD000_0000 + 32'(i));
    end
    repeat (3) @(negedge clk);
    a0 = acc_count;
    auto_ready = 1'b1;
    @(negedge clk);
    auto_ready = 1'b0;
    check("t2_one_accept", acc_count - a0, 1);
    @(negedge clk);
    check("t2_ready_while_wait", dispatch_ready, 0);
    @(negedge clk);
    check("t2_ready_after_free", dispatch_ready, 1);
    dispatch(5'd8);
    check("t2_full_again", dispatch_ready, 0);
    fill(5'd8, 32'h0000_2022, 4'b0001, 32'hD000_0008);
    do_commit(5'd8, 32'h0000_2020, 4'b0001, 32'hD000_0008);
    auto_ready = 1'b1;
    wait_drain();

    // Out-of-order AGU results; fill and dispatch in the same cycle
    dispatch(5'd4);
    dispatch(5'd5);
    fill(5'd5, 32'h0000_3105, 4'b0010, 32'h0000_5500);
    check("t3_wait_rob4", commit_head_ready, 0);
    op(1'b1, 5'd6, 1'b1, 5'd4, 32'h0000_3100, 4'b0001, 32'h0000_0044, 1'b0, 1'b0);
    do_commit(5'd4, 32'h0000_3100, 4'b0001, 32'h0000_0044);
    do_commit(5'd5, 32'h0000_3104, 4'b0010, 32'h0000_5500);
    fill(5'd6, 32'h0000_310B, 4'b1000, 32'h6600_0000);
    do_commit(5'd6, 32'h0000_3108, 4'b1000, 32'h6600_0000);
    wait_drain();

    // Flush with two committed and three uncommitted entries
    auto_ready = 1'b0;
    a0 = acc_count;
    for (int i = 10; i < 15; i++) dispatch(5'(i));
    fill(5'd10, 32'h0000_3003, 4'b1000, 32'h1100_0000);
    fill(5'd11, 32'h0000_3004, 4'b0001, 32'h0000_0022);
    fill(5'd12, 32'h0000_3008, 4'b1111, 32'h1212_1212);
    do_commit(5'd10, 32'h0000_3000, 4'b1000, 32'h1100_0000);
    do_commit(5'd11, 32'h0000_3004, 4'b0001, 32'h0000_0022);
    op(1'b1, 5'd20, 1'b1, 5'd13, 32'h0000_3999, 4'b1111, 32'hBAD0_BAD0, 1'b0, 1'b1);
    check("t4_ready_after_flush", dispatch_ready, 1);
    check("t4_head_empty", commit_head_ready, 0);
    dispatch(5'd15);
    fill(5'd13, 32'h0000_3999, 4'b1111, 32'hBAD0_BAD0);
    check("t4_squashed_not_filled", commit_head_ready, 0);
    fill(5'd15, 32'h0000_3011, 4'b0110, 32'h0033_3300);
    do_commit(5'd15, 32'h0000_3010, 4'b0110, 32'h0033_3300);

    // Back-pressure: request held stable
    for (int k = 0; k < 10; k++) begin
      check("t5_req_valid", dmem_req_valid, 1);
      check("t5_req_addr", dmem_addr, 32'h0000_3000);
      check("t5_req_mask", dmem_wmask, 4'b1000);
      check("t5_req_data", dmem_wdata, 32'h1100_0000);
      @(negedge clk);
    end
    check("t5_no_accept", acc_count - a0, 0);
    auto_ready = 1'b1;
    wait_drain();
    check("t4_drain_count", acc_count - a0, 3);

    // Reset while waiting for the cache response
    resp_en = 1'b0;
    a0 = acc_count;
    dispatch(5'd7);
    fill(5'd7, 32'h0000_4001, 4'b0010, 32'h0000_EE00);
    do_commit(5'd7, 32'h0000_4000, 4'b0010, 32'h0000_EE00);
    for (int k = 0; k < 20 && acc_count == a0; k++) @(negedge clk);
    auto_ready = 1'b0;
    check("t6_accepted", acc_count - a0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    stray_cnt++;
    repeat (3) @(negedge clk);
    check("t6_dispatch_ready", dispatch_ready, 1);
    check("t6_head_ready", commit_head_ready, 0);
    check("t6_head_rob", commit_head_rob_id, 0);
    check("t6_req_valid", dmem_req_valid, 0);
    auto_ready = 1'b1;
    dispatch(5'd9);
    fill(5'd9, 32'h0000_5000, 4'b1111, 32'hCAFE_F00D);
    do_commit(5'd9, 32'h0000_5000, 4'b1111, 32'hCAFE_F00D);
    wait_drain();

    check("final_sb_empty", exp_q.size(), 0);
    check("final_accept_count", acc_count, push_count);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
